// File: rtl/axon_spike_buffer.sv
// Input stage for Neuron: buffers 32-bit spike packets, decodes each one to an axon bit,
// and on every time-step tick hands the accumulated spike vector to Neuron with a start pulse.
module axon_spike_buffer #(
  parameter int PACKET_SIZE        = 32,
  parameter int NUM_AXONS          = 2,
  parameter int AXON_CNT_BIT_WIDTH = 1,
  parameter int X_ID               = 1,
  parameter int Y_ID               = 1,
  parameter int FIFO_DEPTH         = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   tick,
  input  logic [PACKET_SIZE-1:0] pkt_in,
  input  logic                   pkt_valid,
  output logic                   pkt_ready,
  output logic [NUM_AXONS-1:0]   in_spike,
  output logic                   start,
  output logic [15:0]            drop_cnt,
  output logic                   tick_overrun
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int ENT_W = 24;
  localparam logic [3:0]       MY_X      = 4'(X_ID);
  localparam logic [3:0]       MY_Y      = 4'(Y_ID);
  localparam logic [PTR_W:0]   FULL_CNT  = (PTR_W + 1)'(FIFO_DEPTH);
  localparam logic [15:0]      AXON_LIM  = 16'(NUM_AXONS);

  typedef enum logic [1:0] {RUN, SWAP, START} state_t;

  state_t state_q, state_d;

  logic [ENT_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   count;
  logic             full, empty, push, pop;
  logic             pop_stall;
  logic             hit, drop;
  logic [ENT_W-1:0] head;
  logic [NUM_AXONS-1:0] pending, set_vec;
  logic             unused_rsvd;

  // Only the destination and axon fields are kept; the reserved byte never affects decode.
  assign unused_rsvd = ^pkt_in[23:16];

  // Decoder hold point; tied off in the design, lets a bench freeze the FIFO head.
  assign pop_stall = 1'b0;

  assign full      = (count == FULL_CNT);
  assign empty     = (count == '0);
  assign pkt_ready = !rst && !full;
  assign push      = pkt_valid && pkt_ready;
  assign pop       = !empty && !pop_stall;

  // NOTE: FIFO storage has no reset; an entry is only read when count says it is valid.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {pkt_in[31:24], pkt_in[15:0]};
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head = fifo_mem[rd_ptr];
  assign hit  = pop && (head[23:20] == MY_X) && (head[19:16] == MY_Y) && (head[15:0] < AXON_LIM);
  assign drop = pop && !hit;

  // NOTE: every always_comb output gets a default first, so no latch is inferred.
  always_comb begin
    set_vec = '0;
    if (hit) set_vec[head[AXON_CNT_BIT_WIDTH-1:0]] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    case (state_q)
      RUN:     if (tick) state_d = SWAP;
      SWAP:    state_d = START;
      START: begin
        start   = 1'b1;
        state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= RUN;
      pending      <= '0;
      in_spike     <= '0;
      drop_cnt     <= '0;
      tick_overrun <= 1'b0;
    end else begin
      state_q <= state_d;
      // The pop in the SWAP cycle is folded straight into the outgoing vector.
      if (state_q == SWAP) begin
        in_spike <= pending | set_vec;
        pending  <= '0;
      end else begin
        pending  <= pending | set_vec;
      end
      if (drop && (drop_cnt != 16'hFFFF)) drop_cnt <= drop_cnt + 16'd1;
      if (tick && (state_q != RUN))       tick_overrun <= 1'b1;
    end
  end

endmodule
